// File: rtl/menu_ctrl.sv
// menu_ctrl: frame-synchronous PONG menu controller.
//   Conditions four raw push-buttons (2-FF sync, debounce, rising-edge press
//   event), moves a cursor over four menu boxes, publishes the highlighted
//   box once per frame at the vblnk_in rising edge, and sequences
//   MENU -> START -> GAME -> PAUSE -> MENU.
// Ports:
//   pclk, rst           pixel clock, synchronous active-high reset
//   btn_up/down/sel/back raw asynchronous active-high buttons
//   vblnk_in            vertical blank from the timing chain
//   game_over           game-logic level, only looked at in GAME
//   hilite_idx          frame-stable highlighted box (0 = top)
//   sel_idx             mode latched when sel is pressed in MENU
//   game_start          one-cycle strobe, high exactly while state=START
//   menu_active, paused registered decodes of the state
//   state               MENU=0, START=1, GAME=2, PAUSE=3
// Build option: define MENU_WRAP_EN to make the cursor wrap at the ends;
//   otherwise it saturates at 0 and 3.
module menu_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 65000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       btn_back,
  input  logic       vblnk_in,
  input  logic       game_over,
  output logic [1:0] hilite_idx,
  output logic [1:0] sel_idx,
  output logic       game_start,
  output logic       menu_active,
  output logic       paused,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    START = 2'd1,
    GAME  = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam int unsigned    CW       = 20;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t      cur_state;
  state_t      nxt_state;

  // Button bit order: 0 = up, 1 = down, 2 = sel, 3 = back.
  logic [3:0]  raw;
  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic [3:0]  db;
  logic [3:0]  db_q;
  logic [3:0]  press;
  logic [CW-1:0] cnt [4];

  logic        ev_up;
  logic        ev_down;
  logic        ev_sel;
  logic        ev_back;

  logic [1:0]  cursor;
  logic [1:0]  cursor_nxt;
  logic        vblnk_q;
  logic        vblnk_rise;

  assign raw = {btn_back, btn_sel, btn_down, btn_up};

  // Synchroniser, debounce and press detection. The press pulse is
  // registered so outputs driven from it stay glitch-free.
  always_ff @(posedge pclk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      press <= db & ~db_q;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= ~db[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_ONE;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign ev_up      = press[0];
  assign ev_down    = press[1];
  assign ev_sel     = press[2];
  assign ev_back    = press[3];
  assign vblnk_rise = vblnk_in & ~vblnk_q;

  // Cursor movement: MENU only, sel takes priority, up+down cancel.
  always_comb begin
    cursor_nxt = cursor;
    if (cur_state == MENU && !ev_sel) begin
      if (ev_up && !ev_down) begin
`ifdef MENU_WRAP_EN
        cursor_nxt = cursor - 2'd1;
`else
        if (cursor != 2'd0) cursor_nxt = cursor - 2'd1;
`endif
      end else if (ev_down && !ev_up) begin
`ifdef MENU_WRAP_EN
        cursor_nxt = cursor + 2'd1;
`else
        if (cursor != 2'd3) cursor_nxt = cursor + 2'd1;
`endif
      end
    end
  end

  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      MENU:  if (ev_sel) nxt_state = START;
      START: nxt_state = GAME;
      GAME: begin
        if (game_over)    nxt_state = MENU;
        else if (ev_back) nxt_state = PAUSE;
      end
      PAUSE: begin
        if (ev_back)     nxt_state = MENU;
        else if (ev_sel) nxt_state = GAME;
      end
      default: nxt_state = MENU;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the
  // same edge as the state register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      cur_state   <= MENU;
      cursor      <= '0;
      hilite_idx  <= '0;
      sel_idx     <= '0;
      game_start  <= 1'b0;
      menu_active <= 1'b1;
      paused      <= 1'b0;
      vblnk_q     <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      cursor      <= cursor_nxt;
      vblnk_q     <= vblnk_in;
      if (vblnk_rise) hilite_idx <= cursor;
      if (cur_state == MENU && ev_sel) sel_idx <= cursor;
      game_start  <= (nxt_state == START);
      menu_active <= (nxt_state == MENU);
      paused      <= (nxt_state == PAUSE);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_menu_ctrl.sv
// tb_menu_ctrl: self-checking bench for menu_ctrl with DEBOUNCE_CYCLES=4.
// Directed scenarios followed by randomized stimulus; every cycle the DUT
// outputs are compared with a behavioural reference model.
module tb_menu_ctrl;
  localparam int unsigned DB = 4;
`ifdef MENU_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       pclk = 1'b0;
  logic       rst;
  logic [3:0] btns;
  logic       vblnk_in;
  logic       game_over;
  logic       btn_up, btn_down, btn_sel, btn_back;
  logic [1:0] hilite_idx, sel_idx, state;
  logic       game_start, menu_active, paused;

  assign btn_up   = btns[0];
  assign btn_down = btns[1];
  assign btn_sel  = btns[2];
  assign btn_back = btns[3];

  always #5 pclk = ~pclk;

  menu_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .pclk(pclk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel), .btn_back(btn_back),
    .vblnk_in(vblnk_in), .game_over(game_over),
    .hilite_idx(hilite_idx), .sel_idx(sel_idx), .game_start(game_start),
    .menu_active(menu_active), .paused(paused), .state(state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: states as plain integers 0..3, cursor with arithmetic.
  int m_state, m_cursor, m_hilite, m_sel, m_gs, m_menu, m_paused, m_vbq;
  int m_s1[4], m_s2[4], m_db[4], m_dbq[4], m_run[4], m_ev[4];

  function automatic int move(input int c, input int d);
    int n;
    n = c + d;
    if (WRAP) return (n + 4) % 4;
    if (n < 0) return 0;
    if (n > 3) return 3;
    return n;
  endfunction

  task automatic model_step();
    int ns, nc;
    if (rst) begin
      m_state = 0; m_cursor = 0; m_hilite = 0; m_sel = 0;
      m_gs = 0; m_menu = 1; m_paused = 0; m_vbq = 0;
      for (int b = 0; b < 4; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_dbq[b] = 0; m_run[b] = 0; m_ev[b] = 0;
      end
      return;
    end
    ns = m_state;
    nc = m_cursor;
    case (m_state)
      0: begin
        if (m_ev[2] != 0) begin
          m_sel = m_cursor;
          ns = 1;
        end else if (m_ev[0] != 0 && m_ev[1] == 0) nc = move(m_cursor, -1);
        else if (m_ev[1] != 0 && m_ev[0] == 0) nc = move(m_cursor, 1);
      end
      1: ns = 2;
      2: begin
        if (game_over) ns = 0;
        else if (m_ev[3] != 0) ns = 3;
      end
      default: begin
        if (m_ev[3] != 0) ns = 0;
        else if (m_ev[2] != 0) ns = 2;
      end
    endcase
    if (vblnk_in && m_vbq == 0) m_hilite = m_cursor;
    m_vbq    = int'(vblnk_in);
    m_cursor = nc;
    m_state  = ns;
    m_gs     = (ns == 1) ? 1 : 0;
    m_menu   = (ns == 0) ? 1 : 0;
    m_paused = (ns == 3) ? 1 : 0;
    // Button path: event one cycle after the debounced level rises; the
    // debounced level follows the synced level after DB differing cycles.
    for (int b = 0; b < 4; b++) begin
      m_ev[b]  = (m_db[b] == 1 && m_dbq[b] == 0) ? 1 : 0;
      m_dbq[b] = m_db[b];
      if (m_s2[b] != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] == int'(DB)) begin
          m_db[b]  = 1 - m_db[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = int'(btns[b]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge pclk);
    #1;
    check("state",       32'(state),       32'(m_state));
    check("hilite_idx",  32'(hilite_idx),  32'(m_hilite));
    check("sel_idx",     32'(sel_idx),     32'(m_sel));
    check("game_start",  32'(game_start),  32'(m_gs));
    check("menu_active", 32'(menu_active), 32'(m_menu));
    check("paused",      32'(paused),      32'(m_paused));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] mask, input int hold = 6, input int gap = 8);
    btns = mask;
    ticks(hold);
    btns = '0;
    ticks(gap);
  endtask

  task automatic vbl();
    vblnk_in = 1'b1;
    tick();
    vblnk_in = 1'b0;
    tick();
  endtask

  int hold_left[4];
  int vb_left;

  initial begin
    rst = 1'b1; btns = '0; vblnk_in = 1'b0; game_over = 1'b0;
    ticks(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_menu_active", 32'(menu_active), 32'd1);
    rst = 1'b0;

    // Debounce: short press ignored, long press moves the cursor once.
    press(4'b0010, 3, 10);
    vbl();
    check("short_press_hilite", 32'(hilite_idx), 32'd0);
    press(4'b0010, 10, 8);
    check("hilite_before_vbl", 32'(hilite_idx), 32'd0);
    vbl();
    check("hilite_after_vbl", 32'(hilite_idx), 32'd1);

    // Navigation boundaries.
    do_reset();
    for (int i = 0; i < 4; i++) press(4'b0010);
    vbl();
    check("four_downs", 32'(hilite_idx), WRAP ? 32'd0 : 32'd3);
    do_reset();
    press(4'b0001);
    vbl();
    check("up_at_zero", 32'(hilite_idx), WRAP ? 32'd3 : 32'd0);

    // Select from cursor 2.
    do_reset();
    press(4'b0010);
    press(4'b0010);
    press(4'b0100);
    check("sel_state", 32'(state), 32'd2);
    check("sel_idx", 32'(sel_idx), 32'd2);
    check("sel_menu_active", 32'(menu_active), 32'd0);

    // Pause / resume / back to menu.
    press(4'b1000);
    check("pause_state", 32'(state), 32'd3);
    check("pause_flag", 32'(paused), 32'd1);
    press(4'b0100);
    check("resume_state", 32'(state), 32'd2);
    press(4'b1000);
    press(4'b1000);
    check("back_to_menu", 32'(state), 32'd0);
    vbl();
    check("cursor_retained", 32'(hilite_idx), 32'd2);

    // game_over beats a same-cycle back event (event lands on the 8th tick).
    press(4'b0100);
    btns = 4'b1000;
    ticks(7);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("gameover_priority", 32'(state), 32'd0);
    btns = '0;
    ticks(8);
    // Simultaneous up and down cancel.
    press(4'b0011);
    vbl();
    check("updown_cancel", 32'(hilite_idx), 32'd2);

    // Reset mid-game with sel held through reset release.
    press(4'b0010);
    press(4'b0100);
    check("pre_reset_sel_idx", 32'(sel_idx), 32'd3);
    btns = 4'b0100;
    rst = 1'b1;
    tick();
    check("midreset_state", 32'(state), 32'd0);
    check("midreset_sel_idx", 32'(sel_idx), 32'd0);
    check("midreset_hilite", 32'(hilite_idx), 32'd0);
    rst = 1'b0;
    ticks(8);
    check("held_sel_start", 32'(state), 32'd1);
    check("held_sel_strobe", 32'(game_start), 32'd1);
    check("held_sel_idx", 32'(sel_idx), 32'd0);
    btns = '0;
    ticks(10);

    // Randomized phase.
    for (int b = 0; b < 4; b++) hold_left[b] = 0;
    vb_left = 5;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold_left[b] == 0) begin
          btns[b] = ($urandom_range(0, 99) < 35);
          hold_left[b] = int'($urandom_range(1, 12));
        end
        hold_left[b]--;
      end
      if (vb_left == 0) begin
        vblnk_in = ~vblnk_in;
        vb_left = int'($urandom_range(3, 20));
      end
      vb_left--;
      game_over = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 999) < 3);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/menu_ctrl.md
# menu_ctrl

Frame-synchronous controller for the PONG menu renderer and game-state sequencing. Conditions four raw push-buttons (synchronise, debounce, edge-detect) and moves a cursor over the four menu boxes. It publishes the highlighted box to the menu pattern stage once per frame, at vertical blanking, so a frame is never drawn with two different highlights. It also sequences menu → start → game → pause → menu, and emits a one-cycle start strobe carrying the chosen mode.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 65000 (1 ms at 65 MHz). Consecutive stable cycles needed to accept a button level change. Legal range 1..2^20-1.

Ports:
- pclk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- btn_up, btn_down, btn_sel, btn_back  in  1 each  raw, asynchronous, active-high buttons
- vblnk_in  in  1  vertical blank from the timing chain
- game_over  in  1  level from the game logic; sampled only in GAME
- hilite_idx  out  2  box to highlight (0 = top, 3 = bottom); frame-stable
- sel_idx  out  2  mode latched at selection
- game_start  out  1  one-cycle strobe on entering GAME from the menu
- menu_active  out  1  high in MENU; selects menu vs game video path
- paused  out  1  high in PAUSE
- state  out  2  MENU=0, START=1, GAME=2, PAUSE=3

## Operation
- Per button: 2-FF synchroniser, then a debounce counter and a debounced level db.
  - The counter increments each cycle the synchronised level differs from db, and clears whenever they match.
  - On the DEBOUNCE_CYCLES-th consecutive differing cycle, db flips and the counter clears.
  - A press event is a one-cycle pulse on a rising edge of db. Releases generate no event.
- cursor (2 bits, internal), MENU only:
  - up event: cursor−1; down event: cursor+1. Boundary behaviour: see Configuration.
  - up and down events in the same cycle: no move.
- FSM:
  - MENU:
    - sel event → sel_idx ← cursor, go to START. Sel has priority over a same-cycle up/down; the cursor does not move.
    - back event is ignored.
  - START: game_start=1 for this single cycle, then GAME unconditionally.
  - GAME:
    - game_over=1 → MENU.
    - Otherwise a back event → PAUSE.
    - game_over has priority over a same-cycle back. Up, down and sel are ignored.
  - PAUSE:
    - sel → GAME. No game_start pulse.
    - back → MENU.
    - sel and back in the same cycle: back wins.
- The cursor is retained across game rounds. Only rst returns it to 0.
- hilite_idx update:
  - hilite_idx ← cursor on each vblnk_in rising edge, detected with a registered copy of vblnk_in.
  - The sample is the cursor value before any same-cycle update, so a move coinciding with the edge appears one frame later.
- menu_active and paused are decoded from the next state and registered. They change on the same edge as state.

## Timing
- Reset values: hilite_idx=0, sel_idx=0, game_start=0, menu_active=1, paused=0, state=MENU. Also reset to zero: cursor, synchronisers, debounce counters, db levels and the vblnk history register.
- Reset mid-operation (any state, any counter value) fully restarts the block. A button held through reset release yields exactly one press event after debounce.
- With vblnk_in=1 at reset release, the first cycle after reset counts as a rising edge.
- Button latency: raw rising edge at cycle 0 held stable → press event high during cycle DEBOUNCE_CYCLES+3, for one cycle.
- Event to state: next edge. Event to cursor: next edge. Cursor to hilite_idx: next vblnk rising edge.
- game_start is high in exactly the cycle where state=START.
- No handshake with the renderer. Outputs are registered and glitch-free.

## Configuration
- MENU_WRAP_EN defined: the cursor wraps. Up at 0 → 3; down at 3 → 0.
- MENU_WRAP_EN undefined: the cursor saturates. Up at 0 stays 0; down at 3 stays 3.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Debounce: btn_down high for 3 cycles then low → no event, cursor stays 0. Held for 10 cycles → exactly one event at cycle 7; cursor=1; hilite_idx becomes 1 only at the next vblnk_in rise.
- Navigation: four down presses from reset → cursor 1, 2, 3. Fourth press gives 0 with MENU_WRAP_EN and stays 3 without it. Up at cursor 0 → 3 (wrap) / 0 (no wrap).
- Select: cursor=2, sel press → state START for 1 cycle with game_start=1; then GAME, sel_idx=2, menu_active=0.
- Pause/resume: in GAME, back → PAUSE with paused=1. Sel → GAME with no game_start pulse. Back again, then back in PAUSE → MENU with cursor still 2.
- Priority: in GAME, game_over=1 and a back event in the same cycle → MENU, not PAUSE. In MENU, up and down events in the same cycle → cursor unchanged.
- Reset mid-game: assert rst in GAME with sel_idx=3 → all outputs at reset values the next cycle. btn_sel held through reset → one event 7 cycles after release → START with sel_idx=0.
